// File: rtl/alu_req_arbiter.sv
// Purpose: round-robin arbiter that shares one MiniALU between NUM_REQ valid/ready requesters.
// Latency: 3+ALU_LAT cycles per operation (IDLE grant, ISSUE, ALU_LAT x WAIT, RESP).
// Backpressure: response held in RESP until rsp_ready; no request is accepted outside IDLE.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int ALU_LAT = 1,
  parameter int REQ_W   = 3 + 2*W + 1 + 1 + 2 + 3,
  parameter int RSP_W   = W + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*REQ_W-1:0]   req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RSP_W-1:0]           rsp_data,
  output logic                       alu_en,
  output logic [2:0]                 alu_op,
  output logic [W-1:0]               alu_a,
  output logic [W-1:0]               alu_b,
  output logic                       alu_carry_in,
  output logic                       alu_sat_enable,
  output logic [1:0]                 alu_cmp_mode,
  output logic [2:0]                 alu_shift_amt,
  input  logic [W-1:0]               alu_y,
  input  logic                       alu_carry_out,
  input  logic                       alu_zero,
  input  logic                       alu_negative,
  input  logic                       alu_cmp_out,
  output logic [15:0]                op_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_pend_id;
  logic [1:0]        r_wait_cnt;
  logic              r_alu_en;
  logic [2:0]        r_op;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_cin;
  logic              r_sat;
  logic [1:0]        r_cmp;
  logic [2:0]        r_sh;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [RSP_W-1:0]  r_rsp_data;
  logic [15:0]       r_op_count;

  logic              w_any;
  logic              w_hs;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_next_ptr;
  logic [REQ_W-1:0]  w_req_sel;

  // First valid requester scanning upward from r_rr_ptr; descending loop lets the
  // smallest offset from the pointer win.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any     = 1'b1;
        w_gnt_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_hs       = (r_state == IDLE) && !rst && w_any;
  assign req_ready  = w_hs ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_req_sel  = req_data[w_gnt_idx*REQ_W +: REQ_W];
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Control FSM: grant/latch in IDLE, one-cycle enable in ISSUE, count ALU latency,
  // then hold the captured response until it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_pend_id   <= '0;
      r_wait_cnt  <= '0;
      r_alu_en    <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_sat       <= 1'b0;
      r_cmp       <= '0;
      r_sh        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            {r_op, r_a, r_b, r_cin, r_sat, r_cmp, r_sh} <= w_req_sel;
            r_pend_id <= w_gnt_idx;
            r_rr_ptr  <= w_next_ptr;
            r_alu_en  <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_alu_en   <= 1'b0;
          r_wait_cnt <= 2'(ALU_LAT - 1);
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_rsp_data  <= {alu_y, alu_carry_out, alu_zero, alu_negative, alu_cmp_out};
            r_rsp_id    <= r_pend_id;
            r_rsp_valid <= 1'b1;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_data       = r_rsp_data;
  assign alu_en         = r_alu_en;
  assign alu_op         = r_op;
  assign alu_a          = r_a;
  assign alu_b          = r_b;
  assign alu_carry_in   = r_cin;
  assign alu_sat_enable = r_sat;
  assign alu_cmp_mode   = r_cmp;
  assign alu_shift_amt  = r_sh;
  assign op_count       = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed steps with a response scoreboard queue.
// Main instance uses ALU_LAT=1; a second instance uses ALU_LAT=3 with a 3-stage ALU model.
// Outputs are sampled on the falling edge; inputs are driven just after the rising edge.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;

  // ---------------- main instance (ALU_LAT=1) ----------------
  logic [3:0]   req_valid, req_ready;
  logic [103:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [11:0]  rsp_data;
  logic         alu_en, alu_carry_in, alu_sat_enable;
  logic [2:0]   alu_op, alu_shift_amt;
  logic [7:0]   alu_a, alu_b, alu_y;
  logic [1:0]   alu_cmp_mode;
  logic         alu_carry_out, alu_zero, alu_negative, alu_cmp_out;
  logic [15:0]  op_count;
  logic [25:0]  rd [4];

  // ---------------- second instance (ALU_LAT=3) ----------------
  logic [3:0]   b_req_valid, b_req_ready;
  logic [103:0] b_req_data;
  logic         b_rsp_valid, b_rsp_ready;
  logic [1:0]   b_rsp_id;
  logic [11:0]  b_rsp_data;
  logic         b_alu_en, b_alu_carry_in, b_alu_sat_enable;
  logic [2:0]   b_alu_op, b_alu_shift_amt;
  logic [7:0]   b_alu_a, b_alu_b, b_alu_y;
  logic [1:0]   b_alu_cmp_mode;
  logic         b_alu_carry_out, b_alu_zero, b_alu_negative, b_alu_cmp_out;
  logic [15:0]  b_op_count;
  logic [25:0]  b_rd [4];

  assign req_data   = {rd[3], rd[2], rd[1], rd[0]};
  assign b_req_data = {b_rd[3], b_rd[2], b_rd[1], b_rd[0]};

  alu_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry_in(alu_carry_in), .alu_sat_enable(alu_sat_enable),
    .alu_cmp_mode(alu_cmp_mode), .alu_shift_amt(alu_shift_amt),
    .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_cmp_out(alu_cmp_out),
    .op_count(op_count)
  );

  alu_req_arbiter #(.ALU_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .alu_en(b_alu_en), .alu_op(b_alu_op), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_carry_in(b_alu_carry_in), .alu_sat_enable(b_alu_sat_enable),
    .alu_cmp_mode(b_alu_cmp_mode), .alu_shift_amt(b_alu_shift_amt),
    .alu_y(b_alu_y), .alu_carry_out(b_alu_carry_out), .alu_zero(b_alu_zero),
    .alu_negative(b_alu_negative), .alu_cmp_out(b_alu_cmp_out),
    .op_count(b_op_count)
  );

  // Reference MiniALU behaviour: returns {y, carry_out, zero, negative, cmp_out}.
  function automatic logic [11:0] alu_f(input logic [25:0] r);
    logic [2:0] op, sh;
    logic [7:0] a, b, y;
    logic       cin, sat, cmp;
    logic [1:0] cm;
    logic [8:0] s;
    {op, a, b, cin, sat, cm, sh} = r;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      3'd5:    s = {1'b0, a << sh};
      3'd6:    s = {1'b0, a >> sh};
      default: s = {1'b0, ~a};
    endcase
    y = (sat && op == 3'd0 && s[8]) ? 8'hFF : s[7:0];
    case (cm)
      2'd0:    cmp = (a == b);
      2'd1:    cmp = (a < b);
      2'd2:    cmp = (a > b);
      default: cmp = (a != b);
    endcase
    return {y, s[8], (y == 8'h00), y[7], cmp};
  endfunction

  // ALU models: result appears ALU_LAT cycles after the enable edge; zero otherwise.
  logic [11:0] m_pipe;
  logic [11:0] b_pipe [3];
  always @(posedge clk) begin
    m_pipe    <= alu_en ? alu_f({alu_op, alu_a, alu_b, alu_carry_in, alu_sat_enable,
                                 alu_cmp_mode, alu_shift_amt}) : 12'h000;
    b_pipe[0] <= b_alu_en ? alu_f({b_alu_op, b_alu_a, b_alu_b, b_alu_carry_in, b_alu_sat_enable,
                                   b_alu_cmp_mode, b_alu_shift_amt}) : 12'h000;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign {alu_y, alu_carry_out, alu_zero, alu_negative, alu_cmp_out} = m_pipe;
  assign {b_alu_y, b_alu_carry_out, b_alu_zero, b_alu_negative, b_alu_cmp_out} = b_pipe[2];

  int en_cnt   = 0;
  int b_en_cnt = 0;
  always @(posedge clk) begin
    if (alu_en === 1'b1)   en_cnt   <= en_cnt + 1;
    if (b_alu_en === 1'b1) b_en_cnt <= b_en_cnt + 1;
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] dat;
  } exp_t;
  exp_t sbq [$];

  int exp_count = 0;
  int exp_issue = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on the main instance; called just after a rising edge.
  task automatic run_op(input logic [3:0] vld, input int g, input int hold, input bit immediate);
    int n;
    logic [25:0] w;
    exp_t e;
    req_valid = vld;
    rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    while (req_ready === 4'b0000 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("grant", 32'(req_ready), 32'(4'b0001 << g));
    if (immediate) chk("grant_wait", 32'(n), 32'd0);
    w = rd[g];
    sbq.push_back('{id: 2'(g), dat: alu_f(w)});
    exp_issue++;
    @(posedge clk);
    #1;
    rd[g] = 26'($urandom);
    @(negedge clk);
    chk("issue_en", 32'(alu_en), 32'd1);
    chk("issue_a", 32'(alu_a), 32'(w[22:15]));
    chk("issue_b", 32'(alu_b), 32'(w[14:7]));
    chk("issue_ready", 32'(req_ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid) chk("wait_en", 32'(alu_en), 32'd0);
    end while (rsp_valid !== 1'b1 && n < 50);
    chk("rsp_latency", 32'(n), 32'd2);
    e = sbq.pop_front();
    exp_count++;
    chk("rsp_id", 32'(rsp_id), 32'(e.id));
    chk("rsp_data", 32'(rsp_data), 32'(e.dat));
    chk("op_count", 32'(op_count), 32'(exp_count));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'(e.id));
      chk("hold_data", 32'(rsp_data), 32'(e.dat));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [11:0] be;
    rst         = 1'b1;
    req_valid   = 4'b1111;
    rsp_ready   = 1'b0;
    b_req_valid = 4'b0000;
    b_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd[i]   = 26'($urandom);
      b_rd[i] = 26'($urandom);
    end

    // Reset with every requester valid.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_en", 32'(alu_en), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0000;

    // Single request from requester 2: 5 + 3.
    rd[2] = {3'b000, 8'h05, 8'h03, 1'b0, 1'b0, 2'b00, 3'b000};
    run_op(4'b0100, 2, 0, 1'b0);
    chk("add_5_3", 32'(rsp_data), 32'h080);

    // Round robin, all valid; pointer currently at 3.
    run_op(4'b1111, 3, 0, 1'b1);
    for (int i = 0; i < 8; i++) run_op(4'b1111, i % 4, 0, 1'b1);
    run_op(4'b1101, 0, 0, 1'b1);
    run_op(4'b1101, 2, 0, 1'b1);
    run_op(4'b1101, 3, 0, 1'b1);
    run_op(4'b1101, 0, 0, 1'b1);

    // Backpressure for 5 cycles, then next grant in the following IDLE cycle.
    run_op(4'b1111, 1, 5, 1'b1);
    run_op(4'b1111, 2, 0, 1'b1);

    // Reset in the middle of WAIT.
    req_valid = 4'b0100;
    @(negedge clk);
    chk("abandon_grant", 32'(req_ready), 32'(4'b0100));
    exp_issue++;
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abandon_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("abandon_op_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    run_op(4'b1010, 1, 0, 1'b1);
    chk("main_en_pulses", 32'(en_cnt), 32'(exp_issue));

    // ALU_LAT=3 instance: one request from requester 1.
    b_req_valid = 4'b0010;
    n = 0;
    @(negedge clk);
    while (b_req_ready === 4'b0000 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("lat3_grant", 32'(b_req_ready), 32'(4'b0010));
    be = alu_f(b_rd[1]);
    @(posedge clk);
    #1;
    b_req_valid = 4'b0000;
    @(negedge clk);
    chk("lat3_issue_en", 32'(b_alu_en), 32'd1);
    chk("lat3_issue_a", 32'(b_alu_a), 32'(b_rd[1][22:15]));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!b_rsp_valid) chk("lat3_wait_en", 32'(b_alu_en), 32'd0);
    end while (b_rsp_valid !== 1'b1 && n < 50);
    chk("lat3_latency", 32'(n), 32'd4);
    chk("lat3_rsp_id", 32'(b_rsp_id), 32'd1);
    chk("lat3_rsp_data", 32'(b_rsp_data), 32'(be));
    chk("lat3_op_count", 32'(b_op_count), 32'd1);
    b_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b_rsp_ready = 1'b0;
    @(negedge clk);
    chk("lat3_rsp_done", 32'(b_rsp_valid), 32'd0);
    chk("lat3_en_pulses", 32'(b_en_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
